muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit implementing the RV32M operation set. It is the sequential companion to the single-cycle ALU in the execution stage.
- Accepts one operation through a valid/ready handshake, computes it over DATA_WIDTH iterations, then holds the result until the consumer takes it.
- Supports flush so the pipeline can abort an in-flight operation on redirect.

---
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle, with a valid/ready front and back end.
module muldiv_unit #(
    parameter int data_width  = 32,
    parameter int md_op_width = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [md_op_width-1:0] md_op,
    input  logic [data_width-1:0]  md_din1,
    input  logic [data_width-1:0]  md_din2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [data_width-1:0]  md_dout
);
    localparam int W  = data_width;
    localparam int CW = $clog2(data_width);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [W-1:0]     opa_q, opa_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [W-1:0]     dout_q, dout_d;

    // Request decode: signedness, magnitudes and the cases that skip iteration.
    logic [2:0]   op_in;
    logic         sgn1, sgn2, div_zero, div_ovf;
    logic [W-1:0] mag1, mag2;

    assign op_in = md_op[2:0];

    always_comb begin
        sgn1     = md_din1[W-1] & ((op_in == OP_MULH) | (op_in == OP_MULHSU) |
                                   (op_in == OP_DIV)  | (op_in == OP_REM));
        sgn2     = md_din2[W-1] & ((op_in == OP_MULH) | (op_in == OP_DIV) | (op_in == OP_REM));
        mag1     = sgn1 ? -md_din1 : md_din1;
        mag2     = sgn2 ? -md_din2 : md_din2;
        div_zero = op_in[2] && (md_din2 == '0);
        div_ovf  = op_in[2] && !op_in[0] && (md_din1 == {1'b1, {(W-1){1'b0}}}) && (md_din2 == '1);
    end

    // One iteration step. prod_q holds {partial, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide; opa_q is multiplicand or divisor.
    logic [W:0]     mul_sum, div_rem, div_diff;
    logic [2*W-1:0] mul_next, div_next, iter_next, full;
    logic [W-1:0]   quo, rmd, result;

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opa_q} : {(W+1){1'b0}});
        mul_next = {mul_sum, prod_q[W-1:1]};
        div_rem  = prod_q[2*W-1:W-1];
        div_diff = div_rem - {1'b0, opa_q};
        if (!div_diff[W])
            div_next = {div_diff[W-1:0], prod_q[W-2:0], 1'b1};
        else
            div_next = {div_rem[W-1:0], prod_q[W-2:0], 1'b0};
        iter_next = op_q[2] ? div_next : mul_next;

        full = neg_q ? -iter_next : iter_next;
        quo  = iter_next[W-1:0];
        rmd  = iter_next[2*W-1:W];
        if (op_q[2])
            result = op_q[1] ? (neg_q ? -rmd : rmd) : (neg_q ? -quo : quo);
        else
            result = (op_q == OP_MUL) ? full[W-1:0] : full[2*W-1:W];
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opa_d     = opa_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        dout_d    = dout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            CALC: begin
                prod_d = iter_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(W-1)) begin
                    dout_d  = result;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: begin
                in_ready = 1'b1;
                state_d  = IDLE;
                if (in_valid && !flush) begin
                    op_d  = op_in;
                    cnt_d = '0;
                    if (div_zero) begin
                        dout_d  = op_in[1] ? md_din1 : '1;
                        state_d = DONE;
                    end else if (div_ovf) begin
                        dout_d  = op_in[1] ? '0 : md_din1;
                        state_d = DONE;
                    end else if (op_in[2]) begin
                        opa_d   = mag2;
                        prod_d  = {{W{1'b0}}, mag1};
                        neg_d   = op_in[1] ? sgn1 : (sgn1 ^ sgn2);
                        state_d = CALC;
                    end else begin
                        opa_d   = mag1;
                        prod_d  = {{W{1'b0}}, mag2};
                        neg_d   = sgn1 ^ sgn2;
                        state_d = CALC;
                    end
                end
            end
        endcase

        // Flush wins over accept and consume; partial state is simply abandoned.
        if (flush)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            opa_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            dout_q  <= dout_d;
        end
    end

    assign md_dout = dout_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: RV32M reference model from plain 64-bit
// arithmetic, monitor compares results and accept-to-valid latency.
module tb_muldiv_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]    md_op;
    logic [W-1:0]  md_din1, md_din2, md_dout;

    typedef struct {
        logic [31:0] val;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t pending;
    int   tests = 0, fails = 0, cyc = 0, acc_cyc = 0, acc_cnt = 0;
    bit   prev_ov = 1'b0;
    bit   rand_rdy = 1'b0;

    muldiv_unit #(.data_width(W), .md_op_width(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .md_op(md_op), .md_din1(md_din1), .md_din2(md_din2),
        .out_valid(out_valid), .out_ready(out_ready), .md_dout(md_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb64, ub;
        logic [63:0] p;
        int          ia, ib;
        ia = a; ib = b;
        sa = ia; sb64 = ib; ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb64; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Monitor: records accepts, checks latency on out_valid rise and results on consume.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) chk("spurious_valid", {31'b0, out_valid}, 32'h0);
                else chk("latency", cyc - acc_cyc, sb[0].lat);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("result", md_dout, e.val);
            end
            if (in_valid && in_ready && !flush) begin
                acc_cyc = cyc;
                acc_cnt++;
                sb.push_back(pending);
            end
            prev_ov = out_valid;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n0;
        bit ok;
        n0 = acc_cnt;
        ok = 1'b0;
        pending.val = ref_md(op, a, b);
        pending.lat = ref_lat(op, a, b);
        md_op = op; md_din1 = a; md_din2 = b; in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            if (acc_cnt != n0) ok = 1'b1;
        end
        #1;
        in_valid = 1'b0;
        md_din1 = $urandom; md_din2 = $urandom;
        if (!ok) timeout("accept");
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            if (sb.size() == 0) ok = 1'b1;
        end
        #1;
        if (!ok) timeout("drain");
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        drain();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b, e;
        bit ok;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        md_op = '0; md_din1 = '0; md_din2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_dout", md_dout, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed operations, including signed/unsigned corners and special cases.
        run(3'd0, 32'hFFFF_FFFF, 32'h2);
        run(3'd1, 32'hFFFF_FFFF, 32'h2);
        run(3'd3, 32'hFFFF_FFFF, 32'h2);
        run(3'd2, 32'hFFFF_FFFF, 32'h2);
        run(3'd4, 32'hFFFF_FFF9, 32'h2);
        run(3'd6, 32'hFFFF_FFF9, 32'h2);
        run(3'd5, 32'hFFFF_FFF9, 32'h2);
        run(3'd7, 32'hFFFF_FFF9, 32'h2);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'd5, 32'h5, 32'h0);
        run(3'd7, 32'h5, 32'h0);

        // Backpressure: result held in DONE until consumed.
        out_ready = 1'b0;
        a = $urandom; b = $urandom;
        e = ref_md(3'd1, a, b);
        issue(3'd1, a, b);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            if (out_valid) ok = 1'b1;
        end
        if (!ok) timeout("bp_valid");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'b0, out_valid}, 32'h1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
            chk("bp_dout", md_dout, e);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", {31'b0, in_ready}, 32'h1);
        chk("bp_release_valid", {31'b0, out_valid}, 32'h0);

        // Flush at iteration 10 with a competing request.
        issue(3'd3, $urandom, $urandom);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; md_op = 3'd0; md_din1 = 32'h7; md_din2 = 32'h9;
        pending.val = 32'h3F; pending.lat = W + 1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        chk("flush_in_ready", {31'b0, in_ready}, 32'h1);
        chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_quiet", {31'b0, out_valid}, 32'h0);
        run(3'd3, 32'h0001_0000, 32'h0001_0000);

        // Asynchronous reset in the middle of a multiply.
        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF1);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("arst_dout", md_dout, 32'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run(3'd0, 32'h3, 32'h4);

        // Randomized back-to-back traffic with random consumer stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++)
            issue(3'($urandom_range(0, 7)), pick(), pick());
        @(posedge clk); #2;
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
